instr_encoder: RTL

- Inverse of the core's instruction decode path: accepts structured instruction fields over a valid/ready handshake and packs them into 32-bit RV32I machine words.
- Writes the packed words sequentially into instruction memory through a single write port.
- Serves as the on-chip program loader and self-test instruction generator ahead of CPU release from reset.
- Covers the same opcode set as the decoder: R, I-arith, load, JALR, store, branch, JAL, LUI, AUIPC.

---
 rtl/instr_encoder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs structured RV32I instruction fields into machine words and streams them into instruction memory.
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 1024,
  localparam int               CW        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              fin,
  input  logic              enc_vld,
  output logic              enc_rdy,
  input  logic [3:0]        kind,
  input  logic [2:0]        funct3,
  input  logic              alt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [CW-1:0]     word_cnt,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] word;
  logic [1:0] code;
  logic [6:0] f7;
  logic shift, i_ok, b_ok, j_ok, f3_bad, range_bad, mis, xfer, ok;
  assign enc_rdy = (state == RUN) && (word_cnt < CW'(DEPTH));
  assign done = state == DONE;
  assign xfer = enc_vld && enc_rdy;
  assign ok = code == 2'd0;
  always_comb begin
    word = '0;
    f3_bad = 1'b0;
    range_bad = 1'b0;
    mis = 1'b0;
    f7 = alt ? 7'h20 : 7'h00;
    shift = kind == 4'd1 && (funct3 == 3'd1 || funct3 == 3'd5);
    i_ok = imm == {{20{imm[11]}}, imm[11:0]};
    b_ok = imm == {{19{imm[12]}}, imm[12:0]};
    j_ok = imm == {{11{imm[20]}}, imm[20:0]};
    case (kind)
      4'd0: word = {f7, rs2, rs1, funct3, rd, 7'h33};
      4'd1: begin
        word = shift ? {f7, imm[4:0], rs1, funct3, rd, 7'h13} : {imm[11:0], rs1, funct3, rd, 7'h13};
        f3_bad = shift && alt && funct3 == 3'd1;
        range_bad = shift ? |imm[31:5] : !i_ok;
      end
      4'd2: begin
        word = {imm[11:0], rs1, funct3, rd, 7'h03};
        f3_bad = funct3 == 3'd3 || funct3[2:1] == 2'b11;
        range_bad = !i_ok;
      end
      4'd3: begin
        word = {imm[11:0], rs1, funct3, rd, 7'h67};
        f3_bad = funct3 != 3'd0;
        range_bad = !i_ok;
      end
      4'd4: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'h23};
        f3_bad = funct3 > 3'd2;
        range_bad = !i_ok;
      end
      4'd5: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'h63};
        f3_bad = funct3[2:1] == 2'b01;
        range_bad = !b_ok;
        mis = imm[0];
      end
      4'd6: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
        range_bad = !j_ok;
        mis = imm[0];
      end
      4'd7: begin
        word = {imm[31:12], rd, 7'h37};
        range_bad = |imm[11:0];
      end
      4'd8: begin
        word = {imm[31:12], rd, 7'h17};
        range_bad = |imm[11:0];
      end
      default: f3_bad = 1'b1;
    endcase
    // misalignment outranks range so an odd out-of-range target still reports code 3
    code = f3_bad ? 2'd1 : mis ? 2'd3 : range_bad ? 2'd2 : 2'd0;
  end
  always_comb begin
    state_nx = state;
    if (start)
      state_nx = RUN;
    else if (state == RUN && (fin || (xfer && ok && word_cnt == CW'(DEPTH - 1))))
      state_nx = DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      word_cnt <= '0;
      err <= 1'b0;
      err_code <= 2'd0;
      imem_wr_en <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
    end else begin
      state <= state_nx;
      imem_wr_en <= xfer && ok;
      if (xfer && ok) begin
        imem_addr <= BASE_ADDR + ADDR_W'({word_cnt, 2'b00});
        imem_wdata <= word;
      end
      if (start) begin
        word_cnt <= '0;
        err <= 1'b0;
        err_code <= 2'd0;
      end else if (xfer && ok) begin
        word_cnt <= word_cnt + CW'(1);
      end else if (xfer && !err) begin
        err <= 1'b1;
        err_code <= code;
      end
    end
  end
endmodule
